// File: rtl/arb_requester.sv
// ============================================================================
// Module      : arb_requester
// Description : Requester client for a two-port round-robin arbiter. Accepts a
//               burst command, requests the bus, drives an incrementing data
//               burst while granted, then releases for a fairness window.
//               Optional grant-wait timeout enabled by `define REQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_requester #(
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 8,
    parameter int TIMEOUT   = 16,
    localparam int LEN_W    = $clog2(MAX_BEATS + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_base,
    output logic              req,
    input  logic              gnt,
    output logic              bus_valid,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_last,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_xfer = 2'd2;
    localparam logic [1:0] c_st_rel  = 2'd3;

    localparam logic [LEN_W-1:0]  c_max_len  = LEN_W'(MAX_BEATS);
    localparam logic [LEN_W-1:0]  c_len_zero = '0;
    localparam logic [LEN_W-1:0]  c_len_one  = LEN_W'(1);
    localparam logic [LEN_W-1:0]  c_len_two  = LEN_W'(2);
    localparam logic [DATA_W-1:0] c_data_one = DATA_W'(1);

    logic [1:0]        r_state;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_k;
    logic [DATA_W-1:0] r_base;
    logic              r_cmd_ready;
    logic              r_req;
    logic              r_bus_valid;
    logic [DATA_W-1:0] r_bus_data;
    logic              r_bus_last;
    logic              r_done;
    logic              r_err;
    logic [LEN_W-1:0]  w_len;

`ifdef REQ_TIMEOUT_EN
    localparam int                  c_wait_w   = $clog2(TIMEOUT + 1);
    localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(TIMEOUT - 1);
    localparam logic [c_wait_w-1:0] c_wait_one = c_wait_w'(1);
    logic [c_wait_w-1:0] r_wait;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = |TIMEOUT;
`endif

    // Oversized commands are clipped rather than rejected.
    assign w_len = (cmd_len > c_max_len) ? c_max_len : cmd_len;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_len       <= '0;
            r_k         <= '0;
            r_base      <= '0;
            r_cmd_ready <= 1'b1;
            r_req       <= 1'b0;
            r_bus_valid <= 1'b0;
            r_bus_data  <= '0;
            r_bus_last  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
`ifdef REQ_TIMEOUT_EN
            r_wait      <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (cmd_valid) begin
                        r_len       <= w_len;
                        r_base      <= cmd_base;
                        r_cmd_ready <= 1'b0;
                        if (w_len != c_len_zero) begin
                            r_state <= c_st_req;
                            r_req   <= 1'b1;
`ifdef REQ_TIMEOUT_EN
                            r_wait  <= '0;
`endif
                        end else begin
                            r_state <= c_st_rel;
                            r_done  <= 1'b1;
                        end
                    end
                end
                c_st_req: begin
                    if (gnt) begin
                        r_state     <= c_st_xfer;
                        r_k         <= '0;
                        r_bus_valid <= 1'b1;
                        r_bus_data  <= r_base;
                        r_bus_last  <= (r_len == c_len_one);
                    end
`ifdef REQ_TIMEOUT_EN
                    else if (r_wait == c_wait_max) begin
                        r_state <= c_st_rel;
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_wait <= r_wait + c_wait_one;
                    end
`endif
                end
                c_st_xfer: begin
                    if (!gnt || r_bus_last) begin
                        // Either the burst completed or the grant was lost;
                        // a lost burst is never resumed.
                        r_state     <= c_st_rel;
                        r_req       <= 1'b0;
                        r_bus_valid <= 1'b0;
                        r_bus_data  <= '0;
                        r_bus_last  <= 1'b0;
                        r_done      <= 1'b1;
                        r_err       <= !gnt;
                    end else begin
                        r_k        <= r_k + c_len_one;
                        r_bus_data <= r_bus_data + c_data_one;
                        r_bus_last <= ((r_k + c_len_two) == r_len);
                    end
                end
                c_st_rel: begin
                    r_state     <= c_st_idle;
                    r_cmd_ready <= 1'b1;
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_cmd_ready <= 1'b1;
                    r_req       <= 1'b0;
                    r_bus_valid <= 1'b0;
                    r_bus_last  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign req       = r_req;
    assign bus_valid = r_bus_valid;
    assign bus_data  = r_bus_data;
    assign bus_last  = r_bus_last;
    assign done      = r_done;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_arb_requester.sv
// ============================================================================
// Module      : tb_arb_requester
// Description : Scoreboard bench for arb_requester; the bench plays arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arb_requester;

    localparam int DATA_W    = 8;
    localparam int MAX_BEATS = 8;
    localparam int TIMEOUT   = 16;
    localparam int LEN_W     = $clog2(MAX_BEATS + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [DATA_W-1:0] cmd_base = '0;
    logic              req;
    logic              gnt = 1'b0;
    logic              bus_valid;
    logic [DATA_W-1:0] bus_data;
    logic              bus_last;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    logic [DATA_W:0] exp_beats[$];
    logic            exp_done[$];

    arb_requester #(
        .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clk), .reset(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .cmd_base(cmd_base), .req(req), .gnt(gnt),
        .bus_valid(bus_valid), .bus_data(bus_data), .bus_last(bus_last),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every transferred beat and every done pulse.
    always @(negedge clk) begin
        logic [DATA_W:0] e;
        logic            ee;
        if (bus_valid && gnt) begin
            if (exp_beats.size() == 0) begin
                chk("beat_unexpected", {23'd0, bus_last, bus_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_beats.pop_front();
                chk("beat_data", {24'd0, bus_data}, {24'd0, e[DATA_W-1:0]});
                chk("beat_last", {31'd0, bus_last}, {31'd0, e[DATA_W]});
            end
        end
        if (done) begin
            if (exp_done.size() == 0) begin
                chk("done_unexpected", {31'd0, err}, 32'hFFFF_FFFF);
            end else begin
                ee = exp_done.pop_front();
                chk("done_err", {31'd0, err}, {31'd0, ee});
            end
        end
    end

    task automatic push_burst(input int n, input logic [DATA_W-1:0] base, input int total);
        logic [DATA_W-1:0] d;
        d = base;
        for (int i = 0; i < n; i++) begin
            exp_beats.push_back({(i == total - 1), d});
            d = d + 8'd1;
        end
    endtask

    // Present a command for one edge; afterwards we are in the cycle after accept.
    task automatic send_cmd(input logic [LEN_W-1:0] len, input logic [DATA_W-1:0] base);
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_len   = len;
        cmd_base  = base;
        step();
        cmd_valid = 1'b0;
        chk("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
        chk("req_after_accept", {31'd0, req}, {31'd0, (len != 0)});
    endtask

    // Called in a REQ cycle: grant, run n beats, then check the release window.
    task automatic grant_burst(input int n);
        gnt = 1'b1;
        step();
        repeat (n) step();
        chk("req_rel", {31'd0, req}, 32'd0);
        chk("valid_rel", {31'd0, bus_valid}, 32'd0);
        gnt = 1'b0;
        step();
        chk("req_idle", {31'd0, req}, 32'd0);
        chk("cmd_ready_idle_back", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) step();
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_outs", {19'd0, req, bus_valid, bus_data, bus_last, done, err}, 32'd0);
        rst = 1'b0;
        step();

        // gnt in IDLE is ignored
        gnt = 1'b1;
        step();
        step();
        chk("idle_gnt_req", {31'd0, req}, 32'd0);
        chk("idle_gnt_valid", {31'd0, bus_valid}, 32'd0);
        gnt = 1'b0;
        step();

        // Basic 3-beat burst
        push_burst(3, 8'h10, 3);
        exp_done.push_back(1'b0);
        send_cmd(4'd3, 8'h10);
        grant_burst(3);

        // Data wrap
        push_burst(4, 8'hFE, 4);
        exp_done.push_back(1'b0);
        send_cmd(4'd4, 8'hFE);
        grant_burst(4);

        // Zero-length: no request, immediate done
        exp_done.push_back(1'b0);
        send_cmd(4'd0, 8'h33);
        step();
        chk("zero_req_idle", {31'd0, req}, 32'd0);
        chk("zero_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Length clipped to MAX_BEATS
        push_burst(8, 8'h20, 8);
        exp_done.push_back(1'b0);
        send_cmd(4'd12, 8'h20);
        grant_burst(8);

        // Grant lost after 2 of 5 beats
        push_burst(2, 8'h40, 5);
        exp_done.push_back(1'b1);
        send_cmd(4'd5, 8'h40);
        gnt = 1'b1;
        step();
        step();
        step();
        gnt = 1'b0;
        step();
        chk("drop_req_rel", {31'd0, req}, 32'd0);
        step();
        chk("drop_req_idle", {31'd0, req}, 32'd0);

`ifdef REQ_TIMEOUT_EN
        // Timeout with no grant: req high for exactly TIMEOUT cycles
        exp_done.push_back(1'b1);
        send_cmd(4'd3, 8'h90);
        for (int i = 0; i < TIMEOUT; i++) begin
            chk("to_req_high", {31'd0, req}, 32'd1);
            step();
        end
        chk("to_req_drop", {31'd0, req}, 32'd0);
        step();

        // Grant arriving on the expiry cycle wins
        push_burst(3, 8'hA0, 3);
        exp_done.push_back(1'b0);
        send_cmd(4'd3, 8'hA0);
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        chk("to_edge_req", {31'd0, req}, 32'd1);
        grant_burst(3);
`else
        // Without timeout, REQ waits indefinitely
        push_burst(2, 8'h80, 2);
        exp_done.push_back(1'b0);
        send_cmd(4'd2, 8'h80);
        for (int i = 0; i < TIMEOUT + 4; i++) begin
            chk("wait_req_high", {31'd0, req}, 32'd1);
            step();
        end
        grant_burst(2);
`endif

        // Reset in the middle of a transfer
        push_burst(2, 8'h50, 5);
        send_cmd(4'd5, 8'h50);
        gnt = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        gnt = 1'b0;
        rst = 1'b0;
        chk("mid_rst_req", {31'd0, req}, 32'd0);
        chk("mid_rst_valid", {31'd0, bus_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        step();
        step();

        chk("beats_left", exp_beats.size(), 32'd0);
        chk("dones_left", exp_done.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
